// File: rtl/m68k_bus_arbiter_pkg.sv
// Shared definitions for the 68000 bus arbiter: state encoding and
// status-register bit positions used by the Pi-side register file.
package m68k_bus_arbiter_pkg;

  typedef enum logic [2:0] {
    OWN   = 3'd0,
    DRAIN = 3'd1,
    GRANT = 3'd2,
    EXT   = 3'd3,
    REL   = 3'd4
  } arb_state_e;

  localparam int STATUS_ARB_EN_BIT   = 2;
  localparam int STATUS_EXT_OWNED_BIT = 3;

  // Width of a counter that must reach n-1.
  function automatic int cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/m68k_sync_edge.sv
// N-flop synchroniser with edge pulses taken between the last two stages.
module m68k_sync_edge #(
  parameter int   N       = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [N-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= {N{RST_VAL}};
    else         sync_q <= {sync_q[N-2:0], d_i};
  end

  assign q_o    = sync_q[N-1];
  assign rise_o = ~sync_q[N-1] &  sync_q[N-2];
  assign fall_o =  sync_q[N-1] & ~sync_q[N-2];

endmodule

// File: rtl/m68k_bus_arbiter.sv
// 68000 three-wire bus arbiter for the PiStorm CPLD: hands the bus to external
// DMA masters on BR/BG/BGACK and gates local cycles and bus drivers meanwhile.
module m68k_bus_arbiter
  import m68k_bus_arbiter_pkg::*;
#(
  parameter int GRANT_TIMEOUT = 16,
  parameter int CNT_W         = 16
) (
  input  logic             PI_CLK,
  input  logic             RST_n,
  input  logic             M68K_CLK,
  input  logic             M68K_BR_n,
  input  logic             M68K_BGACK_n,
  input  logic             M68K_AS_n,
  input  logic             arb_en,
  input  logic             local_busy,
  output logic             local_gnt,
  output logic             M68K_BG_n,
  output logic             bus_oe_n,
  output logic             ext_owned,
  output logic [CNT_W-1:0] tenure_cnt
);

  localparam int             TO_W    = cnt_width(GRANT_TIMEOUT);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(GRANT_TIMEOUT - 1);

  logic br_raw, bgack_s, as_s, c7m_fall;
  logic br_s;
  logic br_r, br_f, bg_r, bg_f, as_r, as_f, c7m_q, c7m_r;

  m68k_sync_edge #(.N(2), .RST_VAL(1'b1)) u_sync_br (
    .clk_i(PI_CLK), .rst_ni(RST_n), .d_i(M68K_BR_n),
    .q_o(br_raw), .rise_o(br_r), .fall_o(br_f));

  m68k_sync_edge #(.N(2), .RST_VAL(1'b1)) u_sync_bgack (
    .clk_i(PI_CLK), .rst_ni(RST_n), .d_i(M68K_BGACK_n),
    .q_o(bgack_s), .rise_o(bg_r), .fall_o(bg_f));

  m68k_sync_edge #(.N(2), .RST_VAL(1'b1)) u_sync_as (
    .clk_i(PI_CLK), .rst_ni(RST_n), .d_i(M68K_AS_n),
    .q_o(as_s), .rise_o(as_r), .fall_o(as_f));

  m68k_sync_edge #(.N(3), .RST_VAL(1'b0)) u_sync_c7m (
    .clk_i(PI_CLK), .rst_ni(RST_n), .d_i(M68K_CLK),
    .q_o(c7m_q), .rise_o(c7m_r), .fall_o(c7m_fall));

  logic unused_sync;
  assign unused_sync = ^{br_r, br_f, bg_r, bg_f, as_r, as_f, c7m_q, c7m_r};

  // br_s is the asserted request; bgack_s/as_s stay at bus level (1 = released).
  assign br_s = ~br_raw;

  arb_state_e       state_q, state_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [CNT_W-1:0] tenure_q, tenure_d;
  logic             bg_n_q, bg_n_d, oe_n_q, oe_n_d, ext_q, ext_d, gnt_q, gnt_d;

  always_comb begin
    state_d  = state_q;
    to_cnt_d = to_cnt_q;
    tenure_d = tenure_q;
    if (c7m_fall) begin
      case (state_q)
        OWN:   if (br_s && arb_en) state_d = local_busy ? DRAIN : GRANT;
        DRAIN: begin
          if (!br_s || !arb_en)  state_d = OWN;
          else if (!local_busy)  state_d = GRANT;
        end
        GRANT: begin
          to_cnt_d = to_cnt_q + 1'b1;
          if (!bgack_s && as_s)                   state_d = EXT;
          else if ((!br_s && bgack_s) || !arb_en) state_d = OWN;
          else if (to_cnt_q == TO_LAST)           state_d = OWN;
        end
        EXT: begin
          if (bgack_s) begin
            state_d  = REL;
            tenure_d = tenure_q + 1'b1;
          end
        end
        REL:     state_d = OWN;
        default: state_d = OWN;
      endcase
    end
    if (state_d != GRANT) to_cnt_d = '0;

    // Outputs decode the next state so they land on the same edge as the state.
    bg_n_d = 1'b1;
    oe_n_d = 1'b1;
    ext_d  = 1'b0;
    gnt_d  = 1'b0;
    case (state_d)
      OWN: begin
        oe_n_d = 1'b0;
        gnt_d  = !(br_s && arb_en);
      end
      DRAIN:   oe_n_d = 1'b0;
      GRANT:   bg_n_d = 1'b0;
      EXT:     ext_d  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge PI_CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q  <= OWN;
      to_cnt_q <= '0;
      tenure_q <= '0;
      bg_n_q   <= 1'b1;
      oe_n_q   <= 1'b0;
      ext_q    <= 1'b0;
      gnt_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      to_cnt_q <= to_cnt_d;
      tenure_q <= tenure_d;
      bg_n_q   <= bg_n_d;
      oe_n_q   <= oe_n_d;
      ext_q    <= ext_d;
      gnt_q    <= gnt_d;
    end
  end

  assign M68K_BG_n  = bg_n_q;
  assign bus_oe_n   = oe_n_q;
  assign ext_owned  = ext_q;
  assign local_gnt  = gnt_q;
  assign tenure_cnt = tenure_q;

endmodule
